flash_wb_sequencer: RTL and testbench
=====================================

FLASH_WB_SEQUENCER -- requirements
Module: flash_wb_sequencer

Interface
REQ-001 Parameter CLK_DIV, default 2, system clocks per SPI clock half-period (minimum 1).
REQ-002 Parameter FLASH_BASE, default 24'h000000, flash byte address of the first record.
REQ-003 Parameter MPRJ_DATA_ADDR, default 32'h2600_000C, record address that loads the user-IO data register.
REQ-004 Ports:
- clock  input  1  system clock; the block uses one clock.
- resetb  input  1  reset, asynchronous and active-low.
- flash_csb  output  1  SPI flash chip select, active-low.
- flash_clk  output  1  SPI clock, idle low, mode 0.
- flash_io0  output  1  SPI MOSI.
- flash_io1  input  1  SPI MISO.
- mprj_io_out  output  38  user-IO output data.
- mprj_io_oeb  output  38  user-IO output-enable-bar; 1 = input.
- wbm_cyc_o/wbm_stb_o/wbm_we_o  output  1 each  Wishbone master controls.
- wbm_adr_o  output  32  Wishbone address.
- wbm_dat_o  output  32  Wishbone write data.
- wbm_sel_o  output  4  byte selects, always 4'hF.
- wbm_dat_i  input  32  Wishbone read data.
- wbm_ack_i  input  1  Wishbone acknowledge.
- done  output  1  record stream finished.
- error  output  1  readback mismatch (see Configuration).

Function
REQ-005 After reset release, the block shall drive flash_csb low, send opcode 0x03 then the 24-bit FLASH_BASE MSB-first, then read bytes continuously in a single transaction.
REQ-006 The block shall shift MOSI on the falling edge and sample flash_io1 on the rising edge of flash_clk, MSB first.
REQ-007 The block shall assemble 8-byte records: a 32-bit address then 32-bit data, both big-endian.
REQ-008 An address of 32'hFFFF_FFFF shall terminate the stream: flash_csb goes high, done = 1, and the FSM stays in DONE until reset.
REQ-009 If a record's address equals MPRJ_DATA_ADDR, the data shall load mprj_io_out[31:0] on the next clock; mprj_io_out[37:32] shall stay 0. No Wishbone cycle is issued for that record.
REQ-010 For any other address, the block shall issue a single Wishbone write with cyc = stb = we = 1. These signals shall be held until the first clock with wbm_ack_i = 1, then deasserted the following cycle.
REQ-011 flash_clk shall pause, with csb held low, while a Wishbone cycle is outstanding; streaming resumes after the cycle ends.
REQ-012 FSM states: IDLE, CMD, ADDR, READ, WB_WRITE, WB_READ (when compiled in), DONE. Transitions follow REQ-005 to REQ-011 and REQ-016.
REQ-013 mprj_io_oeb shall be 0 for bits [31:16] and 1 for all other bits, so that bit 3 is left free for an external drive.

Reset
REQ-014 While resetb = 0, the outputs shall be: flash_csb = 1, flash_clk = 0, flash_io0 = 0, mprj_io_out = 0, all Wishbone controls = 0, wbm_adr_o = 0, wbm_dat_o = 0, done = 0, error = 0. The FSM shall be in IDLE.
REQ-015 If reset is asserted mid-transfer or mid-Wishbone-cycle, it shall abort immediately, and the flash read shall restart from FLASH_BASE after release.

Configuration
REQ-016 With macro WB_READBACK_EN defined, each Wishbone write (REQ-010) shall be followed by a read to the same address. A mismatch between wbm_dat_i and the written data shall set error = 1 (sticky) without stopping the stream. Without the macro, no readback occurs and error is tied to 0.

Structure
REQ-017 A shared package shall hold: the FSM state enum, the SPI opcode 0x03, the terminator value 32'hFFFF_FFFF, and the default MPRJ_DATA_ADDR.
REQ-018 A single sub-module, spi_byte_shifter, shall implement the mode-0 byte shift and clock divider. The FSM and Wishbone logic stay at the top level.

Verification
REQ-019 The bench shall cover the following scenarios:
- Flash image {MPRJ_DATA_ADDR, 32'hAB60_0000}, then terminator -> mprj_io_out[31:16] = 16'hAB60, done = 1.
- Image with write 0x3000_0000 <= 0x1234_5678, then MPRJ record 0xAB6A_0000 -> one Wishbone write with that address and data, then mprj_io_out[31:16] = 16'hAB6A.
- Slave holds ack low for 50 cycles -> flash_clk is frozen and csb stays low; streaming resumes after ack.
- resetb pulsed low during the READ state -> all outputs return to reset values; after release, opcode 0x03 and FLASH_BASE are reissued.
- WB_READBACK_EN defined, slave returns 0xDEAD_BEEF for written 0x1234_5678 -> error = 1, and the stream still reaches done = 1.
- CLK_DIV = 1 and CLK_DIV = 4 -> the flash_clk period is 2 and 8 system clocks respectively, with identical data results.

Source files
------------

// File: rtl/flash_wb_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// flash_wb_sequencer_pkg -- FSM states and constants shared by the sequencer
// Revision: 1.0
// ============================================================================
package flash_wb_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CMD      = 3'd1,
        ADDR     = 3'd2,
        READ     = 3'd3,
        WB_WRITE = 3'd4,
        WB_READ  = 3'd5,
        DONE     = 3'd6
    } state_t;

    localparam logic [7:0]  c_SPI_READ_OP            = 8'h03;
    localparam logic [31:0] c_TERMINATOR             = 32'hFFFF_FFFF;
    localparam logic [31:0] c_MPRJ_DATA_ADDR_DEFAULT = 32'h2600_000C;

endpackage
`default_nettype wire

// File: rtl/spi_byte_shifter.sv
`default_nettype none
// ============================================================================
// spi_byte_shifter -- SPI mode-0 byte transfer with programmable clock divider
// Revision: 1.0
// ============================================================================
module spi_byte_shifter #(
    parameter int CLK_DIV = 2
) (
    input  logic       clock,
    input  logic       resetb,
    input  logic       i_start,
    input  logic [7:0] i_tx_byte,
    input  logic       i_miso,
    output logic       o_sclk,
    output logic       o_mosi,
    output logic [7:0] o_rx_byte,
    output logic       o_byte_done
);

    localparam int                 c_DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(CLK_DIV - 1);

    logic               r_active;
    logic [c_DIV_W-1:0] r_div;
    logic [2:0]         r_bit;
    logic               r_sclk;
    logic [7:0]         r_tx;
    logic [7:0]         r_rx;
    logic               r_done;

    // Each byte ends on a falling edge, so sclk always rests low between bytes.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            r_active <= 1'b0;
            r_div    <= '0;
            r_bit    <= 3'd0;
            r_sclk   <= 1'b0;
            r_tx     <= 8'h00;
            r_rx     <= 8'h00;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (!r_active) begin
                if (i_start) begin
                    r_active <= 1'b1;
                    r_tx     <= i_tx_byte;
                    r_div    <= '0;
                    r_bit    <= 3'd0;
                    r_sclk   <= 1'b0;
                end
            end else if (r_div == c_DIV_LAST) begin
                r_div <= '0;
                if (!r_sclk) begin
                    r_sclk <= 1'b1;
                    r_rx   <= {r_rx[6:0], i_miso};
                end else begin
                    r_sclk <= 1'b0;
                    if (r_bit == 3'd7) begin
                        r_active <= 1'b0;
                        r_done   <= 1'b1;
                    end else begin
                        r_bit <= r_bit + 3'd1;
                        r_tx  <= {r_tx[6:0], 1'b0};
                    end
                end
            end else begin
                r_div <= r_div + c_DIV_W'(1);
            end
        end
    end

    assign o_sclk      = r_sclk;
    assign o_mosi      = r_tx[7];
    assign o_rx_byte   = r_rx;
    assign o_byte_done = r_done;

endmodule
`default_nettype wire

// File: rtl/flash_wb_sequencer.sv
`default_nettype none
// ============================================================================
// flash_wb_sequencer -- streams address/data records from SPI flash into
// Wishbone writes and the user-IO data register. Option: WB_READBACK_EN.
// Revision: 1.0
// ============================================================================
module flash_wb_sequencer
    import flash_wb_sequencer_pkg::*;
#(
    parameter int          CLK_DIV        = 2,
    parameter logic [23:0] FLASH_BASE     = 24'h000000,
    parameter logic [31:0] MPRJ_DATA_ADDR = c_MPRJ_DATA_ADDR_DEFAULT
) (
    input  logic        clock,
    input  logic        resetb,
    output logic        flash_csb,
    output logic        flash_clk,
    output logic        flash_io0,
    input  logic        flash_io1,
    output logic [37:0] mprj_io_out,
    output logic [37:0] mprj_io_oeb,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    output logic [3:0]  wbm_sel_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    output logic        done,
    output logic        error
);

    localparam logic [37:0] c_OEB = {6'h3F, 16'h0000, 16'hFFFF};

    state_t      r_state;
    logic        r_start;
    logic [7:0]  r_tx_byte;
    logic [2:0]  r_cnt;
    logic [55:0] r_rec;
    logic        r_csb;
    logic        r_done;
    logic        r_cyc;
    logic        r_stb;
    logic        r_we;
    logic [31:0] r_adr;
    logic [31:0] r_dat;
    logic [31:0] r_io;

    logic        w_byte_done;
    logic [7:0]  w_rx_byte;
    logic [63:0] w_rec;

    assign w_rec = {r_rec, w_rx_byte};

    spi_byte_shifter #(
        .CLK_DIV (CLK_DIV)
    ) u_shifter (
        .clock       (clock),
        .resetb      (resetb),
        .i_start     (r_start),
        .i_tx_byte   (r_tx_byte),
        .i_miso      (flash_io1),
        .o_sclk      (flash_clk),
        .o_mosi      (flash_io0),
        .o_rx_byte   (w_rx_byte),
        .o_byte_done (w_byte_done)
    );

`ifdef WB_READBACK_EN
    logic r_error;
`endif

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            r_state   <= IDLE;
            r_start   <= 1'b0;
            r_tx_byte <= 8'h00;
            r_cnt     <= 3'd0;
            r_rec     <= '0;
            r_csb     <= 1'b1;
            r_done    <= 1'b0;
            r_cyc     <= 1'b0;
            r_stb     <= 1'b0;
            r_we      <= 1'b0;
            r_adr     <= 32'h0;
            r_dat     <= 32'h0;
            r_io      <= 32'h0;
`ifdef WB_READBACK_EN
            r_error   <= 1'b0;
`endif
        end else begin
            r_start <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_csb     <= 1'b0;
                    r_tx_byte <= c_SPI_READ_OP;
                    r_start   <= 1'b1;
                    r_state   <= CMD;
                end
                CMD: if (w_byte_done) begin
                    r_tx_byte <= FLASH_BASE[23:16];
                    r_start   <= 1'b1;
                    r_cnt     <= 3'd0;
                    r_state   <= ADDR;
                end
                ADDR: if (w_byte_done) begin
                    r_start <= 1'b1;
                    r_cnt   <= r_cnt + 3'd1;
                    case (r_cnt)
                        3'd0:    r_tx_byte <= FLASH_BASE[15:8];
                        3'd1:    r_tx_byte <= FLASH_BASE[7:0];
                        default: begin
                            // Dummy 0x00 bytes clock the read data in.
                            r_tx_byte <= 8'h00;
                            r_cnt     <= 3'd0;
                            r_state   <= READ;
                        end
                    endcase
                end
                READ: if (w_byte_done) begin
                    r_rec <= w_rec[55:0];
                    r_cnt <= r_cnt + 3'd1;
                    if (r_cnt != 3'd7) begin
                        r_start <= 1'b1;
                    end else if (w_rec[63:32] == c_TERMINATOR) begin
                        r_csb   <= 1'b1;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end else if (w_rec[63:32] == MPRJ_DATA_ADDR) begin
                        r_io    <= w_rec[31:0];
                        r_start <= 1'b1;
                    end else begin
                        // No start pulse: flash_clk stalls until the bus cycle ends.
                        r_cyc   <= 1'b1;
                        r_stb   <= 1'b1;
                        r_we    <= 1'b1;
                        r_adr   <= w_rec[63:32];
                        r_dat   <= w_rec[31:0];
                        r_state <= WB_WRITE;
                    end
                end
                WB_WRITE: if (wbm_ack_i) begin
                    r_cyc <= 1'b0;
                    r_stb <= 1'b0;
                    r_we  <= 1'b0;
`ifdef WB_READBACK_EN
                    r_state <= WB_READ;
`else
                    r_start <= 1'b1;
                    r_state <= READ;
`endif
                end
`ifdef WB_READBACK_EN
                WB_READ: begin
                    if (!r_cyc) begin
                        r_cyc <= 1'b1;
                        r_stb <= 1'b1;
                    end else if (wbm_ack_i) begin
                        r_cyc <= 1'b0;
                        r_stb <= 1'b0;
                        if (wbm_dat_i != r_dat) begin
                            r_error <= 1'b1;
                        end
                        r_start <= 1'b1;
                        r_state <= READ;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    assign flash_csb   = r_csb;
    assign mprj_io_out = {6'b0, r_io};
    assign mprj_io_oeb = c_OEB;
    assign wbm_cyc_o   = r_cyc;
    assign wbm_stb_o   = r_stb;
    assign wbm_we_o    = r_we;
    assign wbm_adr_o   = r_adr;
    assign wbm_dat_o   = r_dat;
    assign wbm_sel_o   = 4'hF;
    assign done        = r_done;

`ifdef WB_READBACK_EN
    assign error = r_error;
`else
    logic w_unused_rdata;
    assign w_unused_rdata = ^wbm_dat_i;
    assign error          = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_flash_wb_sequencer.sv
`default_nettype none
// ============================================================================
// tb_flash_wb_sequencer -- two sequencers (CLK_DIV 1 and 4) against a SPI
// flash image and a delayed-ack Wishbone slave. Honours WB_READBACK_EN.
// Revision: 1.0
// ============================================================================
module tb_flash_wb_sequencer;

    localparam logic [23:0] c_BASE   = 24'h0A5C31;
    localparam logic [31:0] c_MPRJ   = 32'h2600_000C;
    localparam logic [31:0] c_CMD    = {8'h03, c_BASE};
    localparam logic [37:0] c_OEB    = {6'h3F, 16'h0000, 16'hFFFF};
    localparam int          c_BUDGET = 20000;

    logic       clock  = 1'b0;
    logic       resetb = 1'b0;
    logic [7:0] img [0:31];
    int         ack_delay = 0;
    int         cyc_n = 0;
    int         total = 0;
    int         bad   = 0;

    always #5 clock = ~clock;
    always @(negedge clock) cyc_n <= cyc_n + 1;

    function automatic logic img_bit(int b);
        logic [7:0] v;
        if ((b / 8) >= 32) return 1'b1;
        v = img[b / 8];
        return v[7 - (b % 8)];
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int DIV = (g == 0) ? 1 : 4;

        logic        csb, fclk, io0;
        logic        io1 = 1'b0;
        logic [37:0] io_out, io_oeb;
        logic        cyc, stb, we, done, err;
        logic        ack = 1'b0;
        logic [31:0] adr, dat;
        logic [3:0]  sel;
        logic [31:0] cmd = 32'h0;
        logic [31:0] wr_adr = 32'h0;
        logic [31:0] wr_dat = 32'h0;
        int cnt = 0, starts = 0, wr_n = 0, rd_n = 0, wait_c = 0;
        int freeze_bad = 0, sel_bad = 0, cyc_len = 0, max_cyc = 0, t0 = 0, t1 = 0;

        flash_wb_sequencer #(
            .CLK_DIV        (DIV),
            .FLASH_BASE     (c_BASE),
            .MPRJ_DATA_ADDR (c_MPRJ)
        ) u_dut (
            .clock       (clock),
            .resetb      (resetb),
            .flash_csb   (csb),
            .flash_clk   (fclk),
            .flash_io0   (io0),
            .flash_io1   (io1),
            .mprj_io_out (io_out),
            .mprj_io_oeb (io_oeb),
            .wbm_cyc_o   (cyc),
            .wbm_stb_o   (stb),
            .wbm_we_o    (we),
            .wbm_adr_o   (adr),
            .wbm_dat_o   (dat),
            .wbm_sel_o   (sel),
            .wbm_dat_i   (32'hDEAD_BEEF),
            .wbm_ack_i   (ack),
            .done        (done),
            .error       (err)
        );

        // Flash model: 32 command bits in, then image bits out on falling edges.
        always @(posedge fclk or posedge csb) begin
            if (csb) begin
                cnt = 0;
            end else begin
                if (cnt < 32) cmd = {cmd[30:0], io0};
                if (cnt == 0) t0 = cyc_n;
                if (cnt == 1) t1 = cyc_n;
                cnt = cnt + 1;
            end
        end

        always @(negedge fclk) begin
            if (!csb && cnt >= 32) io1 = img_bit(cnt - 32);
        end

        always @(negedge csb) starts = starts + 1;

        // Wishbone slave with programmable ack latency, plus freeze monitor.
        always @(posedge clock) begin
            if (cyc && stb && !ack) begin
                if (wait_c >= ack_delay) begin
                    ack <= 1'b1;
                    if (we) begin
                        wr_n   = wr_n + 1;
                        wr_adr = adr;
                        wr_dat = dat;
                    end else begin
                        rd_n = rd_n + 1;
                    end
                    if (sel !== 4'hF) sel_bad = sel_bad + 1;
                end else begin
                    wait_c = wait_c + 1;
                end
            end else begin
                ack <= 1'b0;
                wait_c = 0;
            end
            if (cyc) begin
                cyc_len = cyc_len + 1;
                if (cyc_len > max_cyc) max_cyc = cyc_len;
                if (fclk !== 1'b0 || csb !== 1'b0) freeze_bad = freeze_bad + 1;
            end else begin
                cyc_len = 0;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total = total + 1;
        assert (obs === exp) else begin
            bad = bad + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        g_inst[0].starts = 0; g_inst[0].wr_n = 0; g_inst[0].rd_n = 0;
        g_inst[0].freeze_bad = 0; g_inst[0].sel_bad = 0; g_inst[0].max_cyc = 0;
        g_inst[0].cmd = 32'h0;
        g_inst[1].starts = 0; g_inst[1].wr_n = 0; g_inst[1].rd_n = 0;
        g_inst[1].freeze_bad = 0; g_inst[1].sel_bad = 0; g_inst[1].max_cyc = 0;
        g_inst[1].cmd = 32'h0;
    endtask

    task automatic set_rec(input int idx, input logic [31:0] a, input logic [31:0] d);
        logic [63:0] r;
        r = {a, d};
        for (int k = 0; k < 8; k++) img[idx * 8 + k] = r[63 - 8 * k -: 8];
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_ctl0"}, 64'({g_inst[0].csb, g_inst[0].fclk, g_inst[0].io0, g_inst[0].cyc,
                                 g_inst[0].stb, g_inst[0].we, g_inst[0].done, g_inst[0].err}), 64'h80);
        chk({tag, "_ctl1"}, 64'({g_inst[1].csb, g_inst[1].fclk, g_inst[1].io0, g_inst[1].cyc,
                                 g_inst[1].stb, g_inst[1].we, g_inst[1].done, g_inst[1].err}), 64'h80);
        chk({tag, "_io0"},  64'(g_inst[0].io_out), 64'h0);
        chk({tag, "_io1"},  64'(g_inst[1].io_out), 64'h0);
        chk({tag, "_bus0"}, {g_inst[0].adr, g_inst[0].dat}, 64'h0);
        chk({tag, "_bus1"}, {g_inst[1].adr, g_inst[1].dat}, 64'h0);
    endtask

    task automatic run_to_done(input string tag);
        int n;
        n = 0;
        @(negedge clock);
        resetb = 1'b1;
        while (!(g_inst[0].done === 1'b1 && g_inst[1].done === 1'b1) && n < c_BUDGET) begin
            @(negedge clock);
            n = n + 1;
        end
        chk({tag, "_timeout"}, 64'(n >= c_BUDGET), 64'd0);
    endtask

    initial begin
        int n;
        for (int k = 0; k < 32; k++) img[k] = 8'hFF;

        // Reset state
        repeat (3) @(negedge clock);
        check_reset("rst");
        chk("oeb0", 64'(g_inst[0].io_oeb), 64'(c_OEB));
        chk("oeb1", 64'(g_inst[1].io_oeb), 64'(c_OEB));

        // Single MPRJ record then terminator
        set_rec(0, c_MPRJ, 32'hAB60_0000);
        clear_stats();
        run_to_done("p1");
        chk("p1_cmd0",  64'(g_inst[0].cmd), 64'(c_CMD));
        chk("p1_cmd1",  64'(g_inst[1].cmd), 64'(c_CMD));
        chk("p1_io0",   64'(g_inst[0].io_out), 64'h00_AB60_0000);
        chk("p1_io1",   64'(g_inst[1].io_out), 64'h00_AB60_0000);
        chk("p1_csb",   64'({g_inst[0].csb, g_inst[1].csb}), 64'd3);
        chk("p1_nowb",  64'(g_inst[0].wr_n + g_inst[1].wr_n), 64'd0);
        chk("p1_err",   64'({g_inst[0].err, g_inst[1].err}), 64'd0);
        chk("p1_per1",  64'(g_inst[0].t1 - g_inst[0].t0), 64'd2);
        chk("p1_per4",  64'(g_inst[1].t1 - g_inst[1].t0), 64'd8);

        // Wishbone write with slow ack, then MPRJ record
        resetb = 1'b0;
        repeat (2) @(negedge clock);
        set_rec(0, 32'h3000_0000, 32'h1234_5678);
        set_rec(1, c_MPRJ, 32'hAB6A_0000);
        ack_delay = 50;
        clear_stats();
        run_to_done("p2");
        chk("p2_wrn0",  64'(g_inst[0].wr_n), 64'd1);
        chk("p2_wrn1",  64'(g_inst[1].wr_n), 64'd1);
        chk("p2_wr0",   {g_inst[0].wr_adr, g_inst[0].wr_dat}, 64'h3000_0000_1234_5678);
        chk("p2_wr1",   {g_inst[1].wr_adr, g_inst[1].wr_dat}, 64'h3000_0000_1234_5678);
        chk("p2_io0",   64'(g_inst[0].io_out), 64'h00_AB6A_0000);
        chk("p2_io1",   64'(g_inst[1].io_out), 64'h00_AB6A_0000);
        chk("p2_freeze", 64'(g_inst[0].freeze_bad + g_inst[1].freeze_bad), 64'd0);
        chk("p2_stall", 64'(g_inst[0].max_cyc >= 50 && g_inst[1].max_cyc >= 50), 64'd1);
        chk("p2_sel",   64'(g_inst[0].sel_bad + g_inst[1].sel_bad), 64'd0);
        chk("p2_ctl",   64'({g_inst[0].cyc, g_inst[0].stb, g_inst[0].we,
                             g_inst[1].cyc, g_inst[1].stb, g_inst[1].we}), 64'd0);
`ifdef WB_READBACK_EN
        chk("p2_rdn",   64'(g_inst[0].rd_n + g_inst[1].rd_n), 64'd2);
        chk("p2_err",   64'({g_inst[0].err, g_inst[1].err}), 64'd3);
`else
        chk("p2_rdn",   64'(g_inst[0].rd_n + g_inst[1].rd_n), 64'd0);
        chk("p2_err",   64'({g_inst[0].err, g_inst[1].err}), 64'd0);
`endif

        // Reset pulse while streaming data
        resetb = 1'b0;
        repeat (2) @(negedge clock);
        ack_delay = 0;
        clear_stats();
        @(negedge clock);
        resetb = 1'b1;
        n = 0;
        while (g_inst[1].cnt < 40 && n < c_BUDGET) begin
            @(negedge clock);
            n = n + 1;
        end
        chk("p3_reach", 64'(n >= c_BUDGET), 64'd0);
        resetb = 1'b0;
        #1;
        check_reset("p3_mid");
        clear_stats();
        run_to_done("p3");
        chk("p3_cmd0",  64'(g_inst[0].cmd), 64'(c_CMD));
        chk("p3_cmd1",  64'(g_inst[1].cmd), 64'(c_CMD));
        chk("p3_start", 64'({g_inst[0].starts[7:0], g_inst[1].starts[7:0]}), 64'h0101);
        chk("p3_io1",   64'(g_inst[1].io_out), 64'h00_AB6A_0000);
        chk("p3_wr1",   {g_inst[1].wr_adr, g_inst[1].wr_dat}, 64'h3000_0000_1234_5678);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
